// File: rtl/kb_pkg.sv
// Shared PS/2 keyboard definitions: prefix bytes, decoder states and the
// queued event layout {ext, brk, code}.
package kb_pkg;

  localparam logic [7:0]  KB_PFX_EXT = 8'hE0;
  localparam logic [7:0]  KB_PFX_BRK = 8'hF0;
  localparam int unsigned KB_CODE_W  = 8;
  localparam int unsigned KB_EVENT_W = KB_CODE_W + 2;

  typedef struct packed {
    logic                 ext;
    logic                 brk;
    logic [KB_CODE_W-1:0] code;
  } kb_event_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kb_state_t;

  function automatic kb_event_t kb_make_event(input logic ext, input logic brk,
                                              input logic [KB_CODE_W-1:0] code);
    kb_event_t ev;
    ev.ext  = ext;
    ev.brk  = brk;
    ev.code = code;
    return ev;
  endfunction

endpackage

// File: rtl/kb_event_fifo.sv
// First-word-fall-through queue with registered head, empty, full and count.
// Push into a full queue is accepted only when a pop happens on the same edge.
module kb_event_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [CW-1:0]    count_nxt;
  logic [WIDTH-1:0] head_nxt;
  logic             do_push;
  logic             do_pop;

  // Accept/advance decisions and the head value visible after this edge.
  always_comb begin
    do_pop     = rd_en & ~empty;
    do_push    = wr_en & (~full | do_pop);
    rd_ptr_nxt = do_pop ? rd_ptr + AW'(1) : rd_ptr;
    count_nxt  = count + CW'(do_push) - CW'(do_pop);
    head_nxt   = '0;
    if (count_nxt != '0) begin
      // A push into a queue that is (or is becoming) empty lands directly at the head.
      if (do_push && ((count - CW'(do_pop)) == '0)) head_nxt = wr_data;
      else                                          head_nxt = mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
      empty   <= 1'b1;
      full    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr  <= rd_ptr_nxt;
      count   <= count_nxt;
      rd_data <= head_nxt;
      empty   <= (count_nxt == '0);
      full    <= (count_nxt == CW'(DEPTH));
    end
  end

endmodule

// File: rtl/kb_event_ctrl.sv
// PS/2 scan-code decoder: folds E0/F0 prefixes into key events and queues them
// for a consumer, throttling the receiver before the queue can overflow.
module kb_event_ctrl
  import kb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_done_tick,
  input  logic [7:0] scan_code,
  input  logic       rd_event,
  output logic       rx_en,
  output logic       event_valid,
  output logic [7:0] event_code,
  output logic       event_ext,
  output logic       event_brk,
  output logic       overflow
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  kb_state_t               state;
  logic [TW-1:0]           tmo_cnt;
  logic                    push_c;
  kb_event_t               push_ev_c;
  logic [KB_EVENT_W-1:0]   head_raw;
  kb_event_t               head_ev;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic [CW-1:0]           fifo_count;
  logic                    do_pop_c;
  logic                    do_push_c;
  logic [CW-1:0]           occ_nxt_c;

  // Byte classification: which bytes complete an event, and with what flags.
  always_comb begin
    push_c    = 1'b0;
    push_ev_c = '0;
    if (scan_done_tick) begin
      unique case (state)
        ST_IDLE: begin
          push_c    = (scan_code != KB_PFX_EXT) && (scan_code != KB_PFX_BRK);
          push_ev_c = kb_make_event(1'b0, 1'b0, scan_code);
        end
        ST_EXT: begin
          push_c    = (scan_code != KB_PFX_EXT) && (scan_code != KB_PFX_BRK);
          push_ev_c = kb_make_event(1'b1, 1'b0, scan_code);
        end
        ST_BRK: begin
          push_c    = 1'b1;
          push_ev_c = kb_make_event(1'b0, 1'b1, scan_code);
        end
        ST_EXT_BRK: begin
          push_c    = 1'b1;
          push_ev_c = kb_make_event(1'b1, 1'b1, scan_code);
        end
        default: ;
      endcase
    end
  end

  // Prefix FSM; a stalled prefix is abandoned after TIMEOUT_CYC quiet cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      tmo_cnt <= '0;
    end else if (scan_done_tick) begin
      tmo_cnt <= '0;
      unique case (state)
        ST_IDLE: begin
          if (scan_code == KB_PFX_EXT)      state <= ST_EXT;
          else if (scan_code == KB_PFX_BRK) state <= ST_BRK;
        end
        ST_EXT: begin
          if (scan_code == KB_PFX_BRK)      state <= ST_EXT_BRK;
          else if (scan_code != KB_PFX_EXT) state <= ST_IDLE;
        end
        ST_BRK, ST_EXT_BRK: state <= ST_IDLE;
        default:            state <= ST_IDLE;
      endcase
    end else if (state != ST_IDLE) begin
      if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
        state   <= ST_IDLE;
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
    end else begin
      tmo_cnt <= '0;
    end
  end

  kb_event_fifo #(
    .WIDTH (KB_EVENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_c),
    .wr_data (push_ev_c),
    .rd_en   (rd_event),
    .rd_data (head_raw),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign head_ev    = kb_event_t'(head_raw);
  assign event_code = head_ev.code;
  assign event_ext  = head_ev.ext;
  assign event_brk  = head_ev.brk;

  // Mirror of the queue's accept rules so status flags can be registered.
  always_comb begin
    do_pop_c  = rd_event & ~fifo_empty;
    do_push_c = push_c & (~fifo_full | do_pop_c);
    occ_nxt_c = fifo_count + CW'(do_push_c) - CW'(do_pop_c);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      event_valid <= 1'b0;
      rx_en       <= 1'b1;
      overflow    <= 1'b0;
    end else begin
      event_valid <= (occ_nxt_c != '0);
      rx_en       <= (occ_nxt_c < CW'(FIFO_DEPTH - 1));
      overflow    <= overflow | (push_c & fifo_full & ~do_pop_c);
    end
  end

endmodule

// File: tb/tb_kb_event_ctrl.sv
// Directed bench for kb_event_ctrl with an expected-event scoreboard.
module tb_kb_event_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scan_done_tick = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       rd_event = 1'b0;
  logic       rx_en;
  logic       event_valid;
  logic [7:0] event_code;
  logic       event_ext;
  logic       event_brk;
  logic       overflow;

  int total = 0;
  int bad   = 0;
  logic [9:0] sb [$];

  kb_event_ctrl #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .scan_done_tick (scan_done_tick),
    .scan_code      (scan_code),
    .rd_event       (rd_event),
    .rx_en          (rx_en),
    .event_valid    (event_valid),
    .event_code     (event_code),
    .event_ext      (event_ext),
    .event_brk      (event_brk),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: present one byte for exactly one rising edge.
  task automatic send(input logic [7:0] b);
    scan_code      = b;
    scan_done_tick = 1'b1;
    @(negedge clk);
    scan_done_tick = 1'b0;
    scan_code      = 8'h00;
  endtask

  task automatic expect_ev(input logic ext, input logic brk, input logic [7:0] code);
    sb.push_back({ext, brk, code});
  endtask

  task automatic pop_check(input string tag);
    logic [9:0] e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s scoreboard empty observed=%0h expected=none", tag,
             {event_ext, event_brk, event_code});
    end else begin
      e = sb.pop_front();
      check({tag, "_valid"}, 32'(event_valid), 32'(1));
      check({tag, "_head"}, 32'({event_ext, event_brk, event_code}), 32'(e));
    end
    rd_event = 1'b1;
    @(negedge clk);
    rd_event = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [9:0] e;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(event_valid), 32'(0));
    check("rst_head", 32'({event_ext, event_brk, event_code}), 32'(0));
    check("rst_rx_en", 32'(rx_en), 32'(1));
    check("rst_ovf", 32'(overflow), 32'(0));
    reset = 1'b0;
    @(negedge clk);

    // Plain make code, latency one cycle
    expect_ev(1'b0, 1'b0, 8'h1C);
    scan_code = 8'h1C;
    scan_done_tick = 1'b1;
    check("lat0_valid", 32'(event_valid), 32'(0));
    @(negedge clk);
    scan_done_tick = 1'b0;
    check("lat1_valid", 32'(event_valid), 32'(1));
    pop_check("make_1c");
    check("empty_valid", 32'(event_valid), 32'(0));
    check("empty_head", 32'({event_ext, event_brk, event_code}), 32'(0));

    // Break code
    send(8'hF0);
    check("brk_prefix_nopush", 32'(event_valid), 32'(0));
    expect_ev(1'b0, 1'b1, 8'h1C);
    send(8'h1C);
    pop_check("brk_1c");

    // Extended make, extended break, repeated E0
    send(8'hE0);
    expect_ev(1'b1, 1'b0, 8'h75);
    send(8'h75);
    pop_check("ext_75");
    send(8'hE0);
    send(8'hF0);
    check("extbrk_nopush", 32'(event_valid), 32'(0));
    expect_ev(1'b1, 1'b1, 8'h75);
    send(8'h75);
    pop_check("extbrk_75");
    send(8'hE0);
    send(8'hE0);
    expect_ev(1'b1, 1'b0, 8'h75);
    send(8'h75);
    pop_check("ext2_75");
    check("ext2_single", 32'(event_valid), 32'(0));

    // Fill, throttle and overflow
    expect_ev(1'b0, 1'b0, 8'h11);
    send(8'h11);
    expect_ev(1'b0, 1'b0, 8'h22);
    send(8'h22);
    check("rx_en_occ2", 32'(rx_en), 32'(1));
    expect_ev(1'b0, 1'b0, 8'h33);
    send(8'h33);
    check("rx_en_occ3", 32'(rx_en), 32'(0));
    expect_ev(1'b0, 1'b0, 8'h44);
    send(8'h44);
    check("ovf_before", 32'(overflow), 32'(0));
    send(8'h2A);
    check("ovf_set", 32'(overflow), 32'(1));
    pop_check("full_pop1");
    check("rx_en_occ3b", 32'(rx_en), 32'(0));
    pop_check("full_pop2");
    check("rx_en_occ2b", 32'(rx_en), 32'(1));
    pop_check("full_pop3");
    pop_check("full_pop4");
    check("drained_valid", 32'(event_valid), 32'(0));
    check("ovf_sticky", 32'(overflow), 32'(1));

    // Simultaneous push and pop on a full queue
    do_reset();
    check("ovf_cleared", 32'(overflow), 32'(0));
    expect_ev(1'b0, 1'b0, 8'h11);
    send(8'h11);
    expect_ev(1'b0, 1'b0, 8'h22);
    send(8'h22);
    expect_ev(1'b0, 1'b0, 8'h33);
    send(8'h33);
    expect_ev(1'b0, 1'b0, 8'h44);
    send(8'h44);
    e = sb.pop_front();
    check("pp_head", 32'({event_ext, event_brk, event_code}), 32'(e));
    expect_ev(1'b0, 1'b0, 8'h1C);
    scan_code      = 8'h1C;
    scan_done_tick = 1'b1;
    rd_event       = 1'b1;
    @(negedge clk);
    scan_done_tick = 1'b0;
    rd_event       = 1'b0;
    check("pp_valid", 32'(event_valid), 32'(1));
    check("pp_ovf", 32'(overflow), 32'(0));
    check("pp_rx_en", 32'(rx_en), 32'(0));
    pop_check("pp_pop1");
    pop_check("pp_pop2");
    pop_check("pp_pop3");
    pop_check("pp_pop4");
    check("pp_drained", 32'(event_valid), 32'(0));

    // Prefix survives one cycle short of the timeout
    send(8'hE0);
    repeat (TMO - 1) @(negedge clk);
    expect_ev(1'b1, 1'b0, 8'h75);
    send(8'h75);
    pop_check("tmo_edge_75");

    // Prefix abandoned at the timeout
    send(8'hE0);
    repeat (TMO) @(negedge clk);
    check("tmo_nopush", 32'(event_valid), 32'(0));
    expect_ev(1'b0, 1'b0, 8'h1C);
    send(8'h1C);
    pop_check("tmo_1c");

    // Reset discards a pending prefix
    send(8'hF0);
    do_reset();
    check("midrst_valid", 32'(event_valid), 32'(0));
    expect_ev(1'b0, 1'b0, 8'h1C);
    send(8'h1C);
    pop_check("midrst_1c");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kb_event_ctrl.md
KB_EVENT_CTRL -- requirements
Module: kb_event_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, event queue entries (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1_000_000, clk cycles allowed between a prefix byte and its following byte.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port scan_done_tick  input  1  one-cycle strobe from the PS/2 receiver; scan_code is valid in that cycle.
REQ-006 SHALL have port scan_code  input  8  received PS/2 byte.
REQ-007 SHALL have port rd_event  input  1  consumer pop request.
REQ-008 SHALL have port rx_en  output  1  enable to the PS/2 receiver.
REQ-009 SHALL have port event_valid  output  1  queue non-empty.
REQ-010 SHALL have port event_code  output  8  head entry key code.
REQ-011 SHALL have port event_ext  output  1  head entry was E0-prefixed.
REQ-012 SHALL have port event_brk  output  1  head entry is a release (F0-prefixed).
REQ-013 SHALL have port overflow  output  1  sticky flag: an event was dropped.

Function
REQ-014 SHALL implement FSM states IDLE, EXT, BRK, EXT_BRK, evaluated only in cycles with scan_done_tick=1 (except timeout).
REQ-015 IDLE: E0 -> EXT; F0 -> BRK; any other byte -> push {ext=0,brk=0,code}, stay IDLE.
REQ-016 EXT: F0 -> EXT_BRK; E0 -> stay EXT, no push; other -> push {1,0,code}, go IDLE.
REQ-017 BRK: any byte -> push {0,1,code}, go IDLE; EXT_BRK: any byte -> push {1,1,code}, go IDLE.
REQ-018 In EXT/BRK/EXT_BRK a counter SHALL count cycles without scan_done_tick; on reaching TIMEOUT_CYC the FSM SHALL return to IDLE without pushing; the counter clears on every scan_done_tick and in IDLE.
REQ-019 Push SHALL write the queue on the same edge that samples scan_done_tick; event_valid SHALL be high in the next cycle (latency 1).
REQ-020 Queue SHALL be first-word-fall-through: event_code/event_ext/event_brk reflect the head whenever event_valid=1, and are 0 when empty.
REQ-021 rd_event with event_valid=1 SHALL pop one entry at that edge; rd_event when empty SHALL be ignored.
REQ-022 Simultaneous push and pop SHALL both succeed, including when full; occupancy unchanged.
REQ-023 Push when full without a pop SHALL drop the new event, leave the queue intact and set overflow; overflow clears only on reset.
REQ-024 rx_en SHALL be 0 when occupancy >= FIFO_DEPTH-1, else 1 (one slot held in reserve for a byte in flight).
REQ-025 Read/write pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter SHALL be log2(FIFO_DEPTH)+1 bits.

Reset
REQ-026 On reset: FSM=IDLE, timeout counter=0, queue empty, pointers=0, overflow=0, event_valid=0, event_* =0, rx_en=1.
REQ-027 Reset asserted mid-sequence (e.g. after E0) SHALL discard the partial prefix; the next byte after release is decoded from IDLE.

Structure
REQ-028 Prefix constants (8'hE0, 8'hF0), FSM state encodings and the 10-bit event entry layout {ext,brk,code[7:0]} SHALL live in a shared kb package.
REQ-029 The queue SHALL be a separate sub-module kb_event_fifo (parameterised width/depth, FWFT, full/empty/count outputs).

Verification
REQ-030 Bytes 1C -> event {0,0,1C}, event_valid high one cycle after the tick; then F0,1C -> {0,1,1C}.
REQ-031 Bytes E0,75 -> {1,0,75}; E0,F0,75 -> {1,1,75}; E0,E0,75 -> single {1,0,75}.
REQ-032 Push 4 events, no reads: rx_en=0 after the 3rd; 5th byte 2A dropped, overflow=1; pops return the first 4 in order.
REQ-033 Queue full, push 1C and rd_event in same cycle: head popped, 1C appended, event_valid stays 1, overflow stays 0.
REQ-034 Byte E0 then TIMEOUT_CYC idle cycles then 1C -> {0,0,1C}; reset asserted after F0, then 1C -> {0,0,1C}.
